// File: rtl/game_tick_divider.sv
// Divides the system clock into phase-locked 250 ms and 500 ms square waves for the game loop.
// Optional macro GAME_TICK_PULSE_EN adds one-cycle strobes after each rising edge.
module game_tick_divider #(
  parameter int HALF_CYCLES = 12_500_000,
  parameter int CNT_W       = 24
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic en,
  output logic clk_250ms,
  output logic clk_500ms
`ifdef GAME_TICK_PULSE_EN
  ,
  output logic tick_250ms,
  output logic tick_500ms
`endif
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      clk_250ms <= 1'b0;
      clk_500ms <= 1'b0;
    end else if (en) begin
      if (cnt_reg == TERM) begin
        cnt_reg   <= '0;
        clk_250ms <= ~clk_250ms;
        // The slow clock only toggles when the fast one is about to rise, keeping rises aligned.
        if (!clk_250ms) begin
          clk_500ms <= ~clk_500ms;
        end
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

`ifdef GAME_TICK_PULSE_EN
  logic clk_250ms_prev_reg;
  logic clk_500ms_prev_reg;

  // Previous-cycle copies let a rise seen one edge ago be strobed on the following edge.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      clk_250ms_prev_reg <= 1'b0;
      clk_500ms_prev_reg <= 1'b0;
      tick_250ms         <= 1'b0;
      tick_500ms         <= 1'b0;
    end else begin
      clk_250ms_prev_reg <= clk_250ms;
      clk_500ms_prev_reg <= clk_500ms;
      tick_250ms         <= en & clk_250ms & ~clk_250ms_prev_reg;
      tick_500ms         <= en & clk_500ms & ~clk_500ms_prev_reg;
    end
  end
`endif

endmodule

// File: tb/tb_game_tick_divider.sv
// Scoreboard bench for game_tick_divider: stimulus pushes model outputs per edge, a monitor pops and compares.
// Tick outputs are checked only when GAME_TICK_PULSE_EN is defined.
module tb_game_tick_divider;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic en;
  logic clk_250ms;
  logic clk_500ms;
  logic tick_250ms_w;
  logic tick_500ms_w;

  game_tick_divider #(.HALF_CYCLES(N), .CNT_W(4)) dut (
    .clk_100mhz (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clk_250ms  (clk_250ms),
    .clk_500ms  (clk_500ms)
`ifdef GAME_TICK_PULSE_EN
    ,
    .tick_250ms (tick_250ms_w),
    .tick_500ms (tick_500ms_w)
`endif
  );

`ifndef GAME_TICK_PULSE_EN
  assign tick_250ms_w = 1'b0;
  assign tick_500ms_w = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  logic [3:0] exp_q[$];

  // Reference model state: count of enabled edges since reset, plus rise flags from the last edge.
  int   m_e = 0;
  logic m_r250 = 1'b0;
  logic m_r500 = 1'b0;

  function automatic logic f250(int e);
    return ((e / N) % 2) == 1;
  endfunction

  function automatic logic f500(int e);
    return ((e % (4 * N)) >= N) && ((e % (4 * N)) < 3 * N);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic en_v, input logic rst_v);
    logic o250, o500, t250, t500;
    @(negedge clk);
    rst_n = rst_v;
    en    = en_v;
    t250  = 1'b0;
    t500  = 1'b0;
    if (!rst_v) begin
      m_e    = 0;
      m_r250 = 1'b0;
      m_r500 = 1'b0;
    end else begin
      o250 = f250(m_e);
      o500 = f500(m_e);
      if (en_v) m_e++;
`ifdef GAME_TICK_PULSE_EN
      t250 = en_v && m_r250;
      t500 = en_v && m_r500;
`endif
      m_r250 = f250(m_e) && !o250;
      m_r500 = f500(m_e) && !o500;
    end
    exp_q.push_back({f250(m_e), f500(m_e), t250, t500});
  endtask

  // Monitor: one comparison per clock edge once expectations are queued.
  initial begin
    logic [3:0] exp_v, got_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {clk_250ms, clk_500ms, tick_250ms_w, tick_500ms_w};
        edge_no++;
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL edge%0d outputs{c250,c500,t250,t500} got %b want %b", edge_no, got_v, exp_v);
        end
      end
    end
  end

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;

    // Free run from reset: first rise at edge 4, periods 8 and 16.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);

    // Enable gap of 5 cycles at cnt=2.
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1);

    // Asynchronous reset mid-count while clk_250ms is high.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_250ms, clk_500ms, tick_250ms_w, tick_500ms_w} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset outputs got %b want 0000",
               {clk_250ms, clk_500ms, tick_250ms_w, tick_500ms_w});
    end
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);

    // Enable held low from reset: nothing moves.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    // Randomized enable with occasional synchronous-looking reset pulses.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) step(1'b0, 1'b0);
      else step(($urandom_range(0, 9) < 7), 1'b1);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
